// File: rtl/alu_seq_unit.sv
// Multi-cycle execute-stage ALU: logic/arith/compare/shift in one cycle, unsigned mul/divu iterate WIDTH cycles.
// Single-cycle ops complete 1 cycle after start; mul/divu complete WIDTH+1 cycles after start; start ignored while busy.
module alu_seq_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIVU = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  work_hi, work_lo, opnd_b;
  logic              is_div;
  logic [WIDTH-1:0]  alu_res, alu_hi;
  logic [WIDTH-1:0]  nxt_hi, nxt_lo;
  logic [SW-1:0]     shamt;
  logic              b_big;
  logic              iter_go;
  logic              last_iter;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift, div_diff;

  assign shamt     = b[SW-1:0];
  assign b_big     = (b >= WIDTH'(WIDTH));
  assign iter_go   = start && ((op == OP_MUL) || ((op == OP_DIVU) && (b != '0)));
  assign last_iter = (count == CW'(1));
  assign zero      = (res == '0);

  // Single-cycle result; divu only reaches here with b == 0.
  always_comb begin
    alu_res = a + b;
    alu_hi  = '0;
    case (op)
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = b_big ? '0 : (a << shamt);
      OP_SRL:  alu_res = b_big ? '0 : (a >> shamt);
      OP_SRA:  alu_res = b_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      OP_DIVU: begin
        alu_res = '1;
        alu_hi  = a;
      end
      default: alu_res = a + b;
    endcase
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iter_go)   state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      opnd_b      <= '0;
      is_div      <= 1'b0;
      res         <= '0;
      res_hi      <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (iter_go) begin
          work_hi <= '0;
          work_lo <= a;
          opnd_b  <= b;
          is_div  <= (op == OP_DIVU);
          count   <= CW'(WIDTH);
        end else if (start) begin
          res         <= alu_res;
          res_hi      <= alu_hi;
          div_by_zero <= (op == OP_DIVU);
          done        <= 1'b1;
        end
      end else begin
        work_hi <= nxt_hi;
        work_lo <= nxt_lo;
        count   <= count - CW'(1);
        // Results are only published once the last iteration lands.
        if (last_iter) begin
          res         <= nxt_lo;
          res_hi      <= nxt_hi;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit at WIDTH=16.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, zero, div_by_zero;
  logic [15:0] res, res_hi;

  int checks = 0;
  int failures = 0;

  alu_seq_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .res_hi(res_hi),
    .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (res !== 16'h0 || res_hi !== 16'h0 || zero !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0 || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: res=%h res_hi=%h zero=%b busy=%b done=%b dbz=%b, want 0 0 1 0 0 0",
                 k, res, res_hi, zero, busy, done, div_by_zero);
      end
      step();
    end
  endtask

  task automatic test_single_ops();
    logic [3:0]  t_op  [15] = '{4'h0, 4'h9, 4'h4, 4'hC, 4'hA, 4'h1, 4'h2, 4'h3,
                                4'h7, 4'h8, 4'hB, 4'hC, 4'hA, 4'hF, 4'h4};
    logic [15:0] t_a   [15] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001, 16'h0000,
                                16'hF0F0, 16'hF0F0, 16'hA5A5, 16'h00FF, 16'h8000, 16'h8000,
                                16'h0003, 16'h0002, 16'h0001};
    logic [15:0] t_b   [15] = '{16'h0001, 16'h0001, 16'h0001, 16'h0004, 16'h0010, 16'h0001,
                                16'h3C3C, 16'h0F01, 16'h0F0F, 16'h0F00, 16'h0004, 16'h0020,
                                16'h0004, 16'h0003, 16'hFFFF};
    logic [15:0] t_exp [15] = '{16'h0000, 16'h0001, 16'h0000, 16'hF800, 16'h0000, 16'hFFFF,
                                16'h3030, 16'hFFF1, 16'hAAAA, 16'hF000, 16'h0800, 16'hFFFF,
                                16'h0030, 16'h0005, 16'h0001};
    for (int i = 0; i < 15; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (res !== t_exp[i] || res_hi !== 16'h0 || done !== 1'b1 || busy !== 1'b0 ||
          zero !== (t_exp[i] == 16'h0)) begin
        failures++;
        $display("FAIL single[%0d] op=%h: res=%h res_hi=%h done=%b busy=%b zero=%b, want res=%h res_hi=0 done=1 busy=0 zero=%b",
                 i, t_op[i], res, res_hi, done, busy, zero, t_exp[i], (t_exp[i] == 16'h0));
      end
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; op = 4'h0; a = 16'd5; b = 16'd3;
    step();
    op = 4'h1;
    checks++;
    if (res !== 16'd8 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_add: res=%h done=%b want 0008 1", res, done);
    end
    step();
    start = 1'b0;
    checks++;
    if (res !== 16'd2 || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sub: res=%h done=%b want 0002 1", res, done);
    end
  endtask

  task automatic test_mul();
    issue(4'h5, 16'd300, 16'd300);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || res !== 16'd2 || res_hi !== 16'h0) begin
        failures++;
        $display("FAIL mul_busy cyc%0d: busy=%b done=%b res=%h res_hi=%h want 1 0 0002 0000",
                 c, busy, done, res, res_hi);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res !== 16'h5F90 || res_hi !== 16'h0001 || zero !== 1'b0) begin
      failures++;
      $display("FAIL mul_result: done=%b busy=%b res=%h res_hi=%h zero=%b want 1 0 5f90 0001 0",
               done, busy, res, res_hi, zero);
    end
    step();
    checks++;
    if (done !== 1'b0 || res !== 16'h5F90) begin
      failures++;
      $display("FAIL mul_hold: done=%b res=%h want 0 5f90", done, res);
    end
  endtask

  task automatic test_divu();
    issue(4'h6, 16'd100, 16'd7);
    for (int c = 1; c < 17; c++) step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res !== 16'd14 || res_hi !== 16'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL divu_result: done=%b busy=%b res=%h res_hi=%h dbz=%b want 1 0 000e 0002 0",
               done, busy, res, res_hi, div_by_zero);
    end
    step();
    issue(4'h6, 16'd100, 16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res !== 16'hFFFF || res_hi !== 16'd100 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL divu_by_zero: done=%b busy=%b res=%h res_hi=%h dbz=%b want 1 0 ffff 0064 1",
               done, busy, res, res_hi, div_by_zero);
    end
    issue(4'h0, 16'd1, 16'd1);
    checks++;
    if (res !== 16'd2 || res_hi !== 16'h0 || div_by_zero !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL dbz_clear: res=%h res_hi=%h dbz=%b done=%b want 0002 0000 0 1",
               res, res_hi, div_by_zero, done);
    end
  endtask

  task automatic test_handshake();
    issue(4'h5, 16'd3, 16'd5);
    for (int c = 1; c < 5; c++) step();
    start = 1'b1; op = 4'h0; a = 16'd9; b = 16'd9;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || res !== 16'd2) begin
      failures++;
      $display("FAIL hs_ignored: done=%b busy=%b res=%h want 0 1 0002", done, busy, res);
    end
    for (int c = 6; c < 17; c++) step();
    checks++;
    if (done !== 1'b1 || res !== 16'd15 || res_hi !== 16'h0) begin
      failures++;
      $display("FAIL hs_mul: done=%b res=%h res_hi=%h want 1 000f 0000", done, res, res_hi);
    end
    issue(4'h0, 16'd2, 16'd2);
    checks++;
    if (done !== 1'b1 || res !== 16'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hs_followup: done=%b res=%h busy=%b want 1 0004 0", done, res, busy);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    step();
    issue(4'h5, 16'd300, 16'd300);
    for (int c = 1; c < 8; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || res !== 16'h0 || res_hi !== 16'h0 || zero !== 1'b1 ||
        done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b res=%h res_hi=%h zero=%b done=%b dbz=%b want 0 0000 0000 1 0 0",
               busy, res, res_hi, zero, done, div_by_zero);
    end
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_no_done: cycles with done/busy high=%0d want 0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_mul();
    test_divu();
    test_handshake();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised multi-cycle ALU for the MIPS datapath's execute stage. It replaces the purely combinational ALU when multiply and divide are needed. Logic, arithmetic, compare and shift operations complete in one cycle. Unsigned multiply and unsigned divide run iteratively over WIDTH cycles behind a start/busy/done handshake, and produce a second result word (high product or remainder).

## Interface
- WIDTH, 16, operand/result width in bits; legal range 4–64.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  4  operation code, sampled with start.
- a  in  WIDTH  operand 1, sampled with start.
- b  in  WIDTH  operand 2, sampled with start.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; res/res_hi/zero/div_by_zero valid from this cycle.
- res  out  WIDTH  primary result (low product, quotient, or op result).
- res_hi  out  WIDTH  high product half or remainder; 0 for all other ops.
- zero  out  1  res == 0 (combinational from registered res).
- div_by_zero  out  1  last completed op was divu with b == 0.

## Operation
- Op codes:
  - 0000 add.
  - 0001 sub.
  - 0010 and.
  - 0011 or.
  - 0100 sltu (unsigned a<b → 1 else 0).
  - 0101 mul (unsigned, iterative).
  - 0110 divu (unsigned restoring, iterative).
  - 0111 xor.
  - 1000 nor.
  - 1001 slt (two's-complement signed).
  - 1010 sll.
  - 1011 srl.
  - 1100 sra.
  - 1101–1111 behave as add.
- Add and sub wrap modulo 2^WIDTH; no carry or overflow output.
- Shifts:
  - Shift amount is b[$clog2(WIDTH)-1:0].
  - If b ≥ WIDTH as a full value: sll/srl give 0; sra gives all copies of a[WIDTH-1].
- mul:
  - Shift-add, one partial product per cycle, WIDTH iterations.
  - Full 2·WIDTH product: {res_hi, res}.
- divu:
  - Restoring, one quotient bit per cycle, WIDTH iterations.
  - res = quotient, res_hi = remainder.
- divu with b == 0:
  - No iteration; completes like a single-cycle op.
  - res = all ones, res_hi = a, div_by_zero = 1.
  - div_by_zero clears on the next completed op.
- FSM states:
  - IDLE: start with a single-cycle op or divu by 0 → registers written, done next cycle, stay IDLE. start with mul/divu → load operands, count = WIDTH, go to RUN.
  - RUN: one iteration per cycle, count decrements. When the last iteration completes, write results, assert done, go to IDLE.
- Outputs hold their values until the next completed operation.
- start while busy=1 is ignored. No queueing, no error.
- Reset values: res=0, res_hi=0, div_by_zero=0, busy=0, done=0, zero=1, FSM=IDLE, count=0.
- Reset during RUN aborts the operation. No done pulse is produced, and all outputs take their reset values on the next cycle.

## Timing
- Cycle 0 = cycle where start=1 and busy=0.
- Single-cycle ops: done=1 in cycle 1 with results valid; busy stays 0.
- mul/divu (b≠0):
  - busy=1 in cycles 1..WIDTH.
  - busy=0 and done=1 in cycle WIDTH+1 (cycle 17 at WIDTH=16).
  - Results are valid from cycle WIDTH+1.
- Back-to-back:
  - busy=0 in the done cycle, so a new start in that cycle is accepted.
  - Peak throughput is 1 op/cycle for single-cycle ops.
- done is never high for more than one consecutive cycle per accepted start.
- Intermediate iteration values never appear on res/res_hi/zero.

## Test plan
- Reset: assert reset 2 cycles, then release → res=0, res_hi=0, zero=1, busy=0, done=0, div_by_zero=0.
- Single-cycle ops (WIDTH=16), each checked in cycle 1:
  - add a=FFFF, b=0001 → res=0000, zero=1, done=1.
  - slt a=FFFF, b=0001 → res=1.
  - sltu with the same operands → res=0.
  - sra a=8000, b=0004 → res=F800.
  - sll a=0001, b=0010 → res=0000.
- mul a=300, b=300 → busy=1 in cycles 1–16; cycle 17: done=1, res=5F90, res_hi=0001, zero=0.
- divu a=100, b=7 → done in cycle 17, res=14, res_hi=2.
- divu a=100, b=0 → done in cycle 1, res=FFFF, res_hi=100, div_by_zero=1.
- A following add 1+1 → res=2, div_by_zero=0.
- Handshake sequence:
  - start mul 3×5; pulse start with add at cycle 5 → the add is ignored, and cycle 17 shows res=15.
  - start add 2+2 in cycle 17 → cycle 18: res=4, done=1.
- Reset at cycle 8 of mul 300×300 → cycle 9: busy=0, res=0, res_hi=0, zero=1. No done pulse occurs in the following 20 cycles.
